// File: rtl/game_pkg.sv
// Shared VGA 640x480@60 timing constants, game state encoding, palette and
// object record used by the game renderer.
package game_pkg;

    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_TOTAL      = 10'd525;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_PLAY  = 2'd1,
        S_WIN   = 2'd2,
        S_LOSE  = 2'd3
    } game_state_t;

    localparam logic [23:0] C_BLACK   = 24'h000000;
    localparam logic [23:0] C_START   = 24'h202080;
    localparam logic [23:0] C_WIN     = 24'h00A000;
    localparam logic [23:0] C_LOSE    = 24'hA00000;
    localparam logic [23:0] C_BADBUL  = 24'hFF4000;
    localparam logic [23:0] C_GOODBUL = 24'h00FFFF;
    localparam logic [23:0] C_PLAYER  = 24'h2060FF;
    localparam logic [23:0] C_ENEMY   = 24'hFF20A0;
    localparam logic [23:0] C_SHIELD  = 24'hFFFFFF;
    localparam logic [23:0] C_PBAR    = 24'h00FF00;
    localparam logic [23:0] C_EBAR    = 24'hFF0000;

    // flags[0] is squat for sprites and exists for bullets; flags[1] is shield
    localparam int F_SQUAT  = 0;
    localparam int F_ISE    = 0;
    localparam int F_SHIELD = 1;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic [1:0]  flags;
    } obj_t;

    function automatic obj_t make_obj(input logic [10:0] x, input logic [9:0] y,
                                      input logic [1:0] flags);
        obj_t o;
        o.x     = x;
        o.y     = y;
        o.flags = flags;
        return o;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480@60 pixel/line counters with raw (unregistered) sync and blank,
// advancing once per pixel enable.
module vga_timing
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_cnt == H_TOTAL - 10'd1) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_TOTAL - 10'd1) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign hsync   = !((h_cnt >= H_SYNC_START) && (h_cnt <= H_SYNC_END));
    assign vsync   = !((v_cnt >= V_SYNC_START) && (v_cnt <= V_SYNC_END));
    assign blank_n = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE);

endmodule

// File: rtl/game_renderer.sv
// Game renderer: per-frame shadow of game-control outputs, rectangle hit tests
// and colour mux in a 3-stage pixel pipeline. Define RENDER_HP_BAR_EN for HP bars.
module game_renderer
    import game_pkg::*;
#(
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 48,
    parameter int BUL_SZ = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_pix_en,
    input  logic [1:0]         i_state,
    input  logic signed [10:0] i_player_x,
    input  logic signed [10:0] i_enemy_x,
    input  logic signed [10:0] i_goodbullet_x,
    input  logic signed [10:0] i_badbullet_x,
    input  logic signed [9:0]  i_player_y,
    input  logic signed [9:0]  i_enemy_y,
    input  logic signed [9:0]  i_goodbullet_y,
    input  logic signed [9:0]  i_badbullet_y,
    input  logic [1:0]         i_player_hp,
    input  logic [1:0]         i_enemy_hp,
    input  logic               i_player_shield,
    input  logic               i_enemy_shield,
    input  logic               i_player_squat,
    input  logic               i_enemy_squat,
    input  logic               i_goodbullet_isE,
    input  logic               i_badbullet_isE,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_blank_n,
    output logic [7:0]         o_r,
    output logic [7:0]         o_g,
    output logic [7:0]         o_b,
    output logic               o_frame_start
);

    localparam logic signed [11:0] SPR_W_S  = 12'(SPR_W);
    localparam logic signed [11:0] SPR_H_S  = 12'(SPR_H);
    localparam logic signed [11:0] SPR_HF_S = 12'(SPR_H / 2);
    localparam logic signed [11:0] BUL_S    = 12'(BUL_SZ);

    function automatic logic signed [11:0] sext_x(input logic [10:0] x);
        return {x[10], x};
    endfunction

    function automatic logic signed [11:0] sext_y(input logic [9:0] y);
        return {{2{y[9]}}, y};
    endfunction

    function automatic logic covers(input logic signed [11:0] px, input logic signed [11:0] py,
                                    input logic signed [11:0] x0, input logic signed [11:0] y0,
                                    input logic signed [11:0] w, input logic signed [11:0] ht);
        return (px >= x0) && (px < x0 + w) && (py >= y0) && (py < y0 + ht);
    endfunction

    // Squatting keeps the feet row fixed: the top moves down by half the height.
    function automatic logic sprite_hit(input obj_t o, input logic signed [11:0] px,
                                        input logic signed [11:0] py);
        logic signed [11:0] top;
        logic signed [11:0] ht;
        top = sext_y(o.y);
        ht  = SPR_H_S;
        if (o.flags[F_SQUAT]) begin
            top = top + SPR_HF_S;
            ht  = SPR_HF_S;
        end
        return covers(px, py, sext_x(o.x), top, SPR_W_S, ht);
    endfunction

    function automatic logic bullet_hit(input obj_t o, input logic signed [11:0] px,
                                        input logic signed [11:0] py);
        return o.flags[F_ISE] && covers(px, py, sext_x(o.x), sext_y(o.y), BUL_S, BUL_S);
    endfunction

    // ---- Stage 0: counters, raw sync/blank, shadow registers ----
    logic [9:0] h_cnt_p0;
    logic [9:0] v_cnt_p0;
    logic       hsync_p0;
    logic       vsync_p0;
    logic       blank_n_p0;

    vga_timing u_timing (
        .clk     (clk),
        .rst_n   (rst_n),
        .pix_en  (i_pix_en),
        .h_cnt   (h_cnt_p0),
        .v_cnt   (v_cnt_p0),
        .hsync   (hsync_p0),
        .vsync   (vsync_p0),
        .blank_n (blank_n_p0)
    );

    logic        shadow_load;
    game_state_t sh_state;
    obj_t        sh_player;
    obj_t        sh_enemy;
    obj_t        sh_good;
    obj_t        sh_bad;
    logic [1:0]  sh_player_hp;
    logic [1:0]  sh_enemy_hp;
    logic        frame_start_q;

    assign shadow_load = i_pix_en && (h_cnt_p0 == 10'd0) && (v_cnt_p0 == V_ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_state      <= S_START;
            sh_player     <= '0;
            sh_enemy      <= '0;
            sh_good       <= '0;
            sh_bad        <= '0;
            sh_player_hp  <= 2'd3;
            sh_enemy_hp   <= 2'd3;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= shadow_load;
            if (shadow_load) begin
                sh_state     <= game_state_t'(i_state);
                sh_player    <= make_obj(i_player_x, i_player_y, {i_player_shield, i_player_squat});
                sh_enemy     <= make_obj(i_enemy_x, i_enemy_y, {i_enemy_shield, i_enemy_squat});
                sh_good      <= make_obj(i_goodbullet_x, i_goodbullet_y, {1'b0, i_goodbullet_isE});
                sh_bad       <= make_obj(i_badbullet_x, i_badbullet_y, {1'b0, i_badbullet_isE});
                sh_player_hp <= i_player_hp;
                sh_enemy_hp  <= i_enemy_hp;
            end
        end
    end

    logic signed [11:0] px_p0;
    logic signed [11:0] py_p0;
    logic               bad_hit_p0;
    logic               good_hit_p0;
    logic               player_hit_p0;
    logic               enemy_hit_p0;
    logic               pbar_hit_p0;
    logic               ebar_hit_p0;

    assign px_p0         = $signed({2'b00, h_cnt_p0});
    assign py_p0         = $signed({2'b00, v_cnt_p0});
    assign bad_hit_p0    = bullet_hit(sh_bad, px_p0, py_p0);
    assign good_hit_p0   = bullet_hit(sh_good, px_p0, py_p0);
    assign player_hit_p0 = sprite_hit(sh_player, px_p0, py_p0);
    assign enemy_hit_p0  = sprite_hit(sh_enemy, px_p0, py_p0);

`ifdef RENDER_HP_BAR_EN
    logic [11:0] h12_p0;
    logic [11:0] pbar_end_p0;
    logic [11:0] ebar_start_p0;
    logic        bar_row_p0;

    // 32 pixels per HP point; hp=0 collapses both ranges to empty
    assign h12_p0        = {2'b00, h_cnt_p0};
    assign pbar_end_p0   = 12'd16 + {5'b00000, sh_player_hp, 5'b00000};
    assign ebar_start_p0 = 12'd592 - {5'b00000, sh_enemy_hp, 5'b00000};
    assign bar_row_p0    = (v_cnt_p0 >= 10'd8) && (v_cnt_p0 <= 10'd15);
    assign pbar_hit_p0   = bar_row_p0 && (h12_p0 >= 12'd16) && (h12_p0 < pbar_end_p0);
    assign ebar_hit_p0   = bar_row_p0 && (h12_p0 >= ebar_start_p0) && (h12_p0 <= 12'd591);
`else
    assign pbar_hit_p0 = 1'b0;
    assign ebar_hit_p0 = 1'b0;
`endif

    // ---- Stage 1: registered hit flags and sync/blank ----
    logic        hsync_p1;
    logic        vsync_p1;
    logic        blank_n_p1;
    game_state_t state_p1;
    logic        bad_hit_p1;
    logic        good_hit_p1;
    logic        player_hit_p1;
    logic        enemy_hit_p1;
    logic        pbar_hit_p1;
    logic        ebar_hit_p1;
    logic        player_shield_p1;
    logic        enemy_shield_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_p1   <= 1'b1;
            vsync_p1   <= 1'b1;
            blank_n_p1 <= 1'b0;
            state_p1   <= S_START;
        end else if (i_pix_en) begin
            hsync_p1   <= hsync_p0;
            vsync_p1   <= vsync_p0;
            blank_n_p1 <= blank_n_p0;
            state_p1   <= sh_state;
        end
    end

    always_ff @(posedge clk) begin
        if (i_pix_en) begin
            bad_hit_p1       <= bad_hit_p0;
            good_hit_p1      <= good_hit_p0;
            player_hit_p1    <= player_hit_p0;
            enemy_hit_p1     <= enemy_hit_p0;
            pbar_hit_p1      <= pbar_hit_p0;
            ebar_hit_p1      <= ebar_hit_p0;
            player_shield_p1 <= sh_player.flags[F_SHIELD];
            enemy_shield_p1  <= sh_enemy.flags[F_SHIELD];
        end
    end

    logic [23:0] pix_rgb_p1;

    always_comb begin
        pix_rgb_p1 = C_BLACK;
        case (state_p1)
            S_START: pix_rgb_p1 = C_START;
            S_WIN:   pix_rgb_p1 = C_WIN;
            S_LOSE:  pix_rgb_p1 = C_LOSE;
            S_PLAY: begin
                if (pbar_hit_p1)        pix_rgb_p1 = C_PBAR;
                else if (ebar_hit_p1)   pix_rgb_p1 = C_EBAR;
                else if (bad_hit_p1)    pix_rgb_p1 = C_BADBUL;
                else if (good_hit_p1)   pix_rgb_p1 = C_GOODBUL;
                else if (player_hit_p1) pix_rgb_p1 = player_shield_p1 ? C_SHIELD : C_PLAYER;
                else if (enemy_hit_p1)  pix_rgb_p1 = enemy_shield_p1 ? C_SHIELD : C_ENEMY;
                else                    pix_rgb_p1 = C_BLACK;
            end
            default: pix_rgb_p1 = C_BLACK;
        endcase
    end

    // ---- Stage 2: registered colour and outputs ----
    logic        hsync_p2;
    logic        vsync_p2;
    logic        blank_n_p2;
    logic [23:0] rgb_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_p2   <= 1'b1;
            vsync_p2   <= 1'b1;
            blank_n_p2 <= 1'b0;
            rgb_p2     <= '0;
        end else if (i_pix_en) begin
            hsync_p2   <= hsync_p1;
            vsync_p2   <= vsync_p1;
            blank_n_p2 <= blank_n_p1;
            rgb_p2     <= blank_n_p1 ? pix_rgb_p1 : 24'h000000;
        end
    end

    assign o_hsync       = hsync_p2;
    assign o_vsync       = vsync_p2;
    assign o_blank_n     = blank_n_p2;
    assign o_r           = rgb_p2[23:16];
    assign o_g           = rgb_p2[15:8];
    assign o_b           = rgb_p2[7:0];
    assign o_frame_start = frame_start_q;

endmodule

// File: doc/game_renderer.md
# game_renderer

Pixel-stream renderer directly downstream of the game-control block: consumes its state, object positions, HP and flags, and produces 640x480@60 VGA timing plus 24-bit RGB. Game inputs are sampled into shadow registers once per frame, at the start of vertical blanking, so objects never tear mid-frame. Objects are drawn as solid rectangles in a 3-stage pixel pipeline with fixed draw priority.

## Interface
- Parameters:
- `SPR_W`, 32: player/enemy width in pixels.
- `SPR_H`, 48: player/enemy standing height; squatting height is `SPR_H/2`.
- `BUL_SZ`, 8: bullet square edge.
- Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_pix_en`  in  1  pixel-clock enable (one pulse per pixel, e.g. 25 MHz of 50 MHz).
- `i_state`  in  2  game state (START / PLAY / WIN / LOSE).
- `i_player_x`, `i_enemy_x`, `i_goodbullet_x`, `i_badbullet_x`  in  11 signed  left edge.
- `i_player_y`, `i_enemy_y`, `i_goodbullet_y`, `i_badbullet_y`  in  10 signed  top edge.
- `i_player_hp`, `i_enemy_hp`  in  2  remaining HP (0..3).
- `i_player_shield`, `i_enemy_shield`, `i_player_squat`, `i_enemy_squat`  in  1  each.
- `i_goodbullet_isE`, `i_badbullet_isE`  in  1  bullet exists.
- `o_hsync`, `o_vsync`  out  1  active-low syncs.
- `o_blank_n`  out  1  high in the active area.
- `o_r`, `o_g`, `o_b`  out  8 each  colour; zero whenever `o_blank_n` is low.
- `o_frame_start`  out  1  one-`clk` pulse when the shadow registers load.

## Operation
- Timing (`vga_timing`): h counter 0..799, v counter 0..524, both advancing only on `i_pix_en`. Active area h<640, v<480. hsync low for h in 656..751, vsync low for v in 490..491. v increments when h wraps 799->0; v wraps 524->0.
- Shadow load: on the `i_pix_en` at which h==0 and v==480, all `i_*` inputs are copied into shadow registers and `o_frame_start` pulses for that cycle. Rendering uses only shadow values.
- Hit tests, all signed, with operands sign-extended to 12 bits:
  - An object covers pixel (h,v) if x<=h<x+W and y<=v<y+H.
  - Player and enemy use H=`SPR_H`; when squatting, top = y+`SPR_H/2` and H=`SPR_H/2` (feet stay fixed).
  - Bullets use `BUL_SZ` and are drawn only if their isE shadow bit is 1.
  - Negative or off-screen coordinates clip naturally; there is no wrap.
- Colour by shadow state:
  - START: 0x202080.
  - WIN: 0x00A000.
  - LOSE: 0xA00000.
  - PLAY: background 0x000000, with this priority high to low: badbullet 0xFF4000, goodbullet 0x00FFFF, player 0x2060FF (0xFFFFFF if shield), enemy 0xFF20A0 (0xFFFFFF if shield).
- Everything in the pipeline advances only on `i_pix_en`.

## Timing
- Pipeline: S0 counters → S1 registered hit flags and sync/blank → S2 registered RGB and outputs. Syncs, blank and RGB are mutually aligned, with 2 `i_pix_en` latency from the counters.
- Reset values:
  - Counters 0.
  - Shadow state START, positions 0, HP 3, flags 0.
  - `o_hsync`=`o_vsync`=1; `o_blank_n`=0; RGB 0; `o_frame_start`=0.
- Reset mid-frame restarts at h=v=0. No shadow load occurs until the next v==480.
- An input change during the active area has no visible effect until the next frame.

## Configuration
- `RENDER_HP_BAR_EN` defined: in PLAY, two HP bars are drawn, with priority above all objects.
  - Player bar: rows 8..15, columns 16..16+32*hp-1, colour 0x00FF00.
  - Enemy bar: same rows, columns 592-32*hp..591, colour 0xFF0000.
  - hp=0 draws nothing.
- Not defined: no bar logic is instantiated; output is identical to the enabled case with hp=0.

## Structure
- Shared in `game_pkg`:
  - VGA constants (H_ACTIVE, H_TOTAL, sync start/end, V equivalents).
  - State encodings S_START=0, S_PLAY=1, S_WIN=2, S_LOSE=3.
  - Colour constants.
  - `obj_t` typedef {x, y, flags}.
- One sub-module, `vga_timing`: counters, raw sync and blank. The top level holds the shadow registers, hit tests and colour mux.

## Test plan
- Reset held for 10 cycles, then release with `i_pix_en` every 2nd `clk` → hsync period 800 pixels, vsync low exactly 2 lines, 525 lines per frame, `o_frame_start` once per frame.
- PLAY, player at (100,200), no squat → pixel (100,200) is 0x2060FF, (99,200) and (132,200) are black, (100,247) coloured, (100,248) black, each seen 2 `i_pix_en` after the counter value.
- Player squat=1 at y=200 → row 223 black, rows 224..247 coloured. Shield=1 → 0xFFFFFF.
- Badbullet at (100,200) isE=1 overlapping the player → 0xFF4000. Set isE=0 → player colour, and only from the frame after the next `o_frame_start`.
- Enemy at x=-10, y=0 → columns 0..21 coloured on rows 0..47, no wrap at column 630+. Change `i_state` to WIN during line 100 → the frame stays PLAY, and the next frame is solid 0x00A000.
- With `RENDER_HP_BAR_EN`, player hp=2 and enemy hp=1 → green on columns 16..79 and red on columns 560..591 of rows 8..15. Without the macro, those pixels show background or objects.
